// File: rtl/input_trigger_gen_pkg.sv
// Shared constants for the input trigger generator: FSM state codes,
// Edge_Sel encodings and a counter-width helper.
package input_trigger_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  localparam int CNT_W_DEFAULT = 16;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_trigger_gen_if.sv
// Control/status bundle between the trigger generator and its host logic.
interface input_trigger_gen_if #(
  parameter int CNT_W = 16
) ();
  logic             Input_In;
  logic             Enable;
  logic [1:0]       Edge_Sel;
  logic             Count_Clr;
  logic             Input_Level;
  logic             Trigger_Out;
  logic             Trigger_Busy;
  logic [CNT_W-1:0] Trigger_Count;
  logic [CNT_W-1:0] Missed_Count;

  modport master (
    output Input_In, Enable, Edge_Sel, Count_Clr,
    input  Input_Level, Trigger_Out, Trigger_Busy, Trigger_Count, Missed_Count
  );

  modport slave (
    input  Input_In, Enable, Edge_Sel, Count_Clr,
    output Input_Level, Trigger_Out, Trigger_Busy, Trigger_Count, Missed_Count
  );
endinterface

// File: rtl/input_trigger_gen_sync_debounce.sv
// Synchroniser, stable-sample counter and debounced level with a one-cycle
// edge event; the first settle after reset only arms, it never fires.
module input_sync_debounce
  import input_trigger_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic input_raw,
  output logic input_level,
  output logic edge_event,
  output logic edge_rise
);
  localparam int             DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  ONE     = DW'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   prev_r;
  logic [DW-1:0]          stable_r;
  logic [DW-1:0]          stable_next_s;
  logic                   level_r;
  logic                   armed_r;
  logic                   event_r;
  logic                   rise_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Next stable count: restart on a change, otherwise count up to the limit.
  always_comb begin
    stable_next_s = stable_r;
    if (sync_s != prev_r) begin
      stable_next_s = ONE;
    end else if (stable_r != DEB_MAX) begin
      stable_next_s = stable_r + ONE;
    end else begin
      stable_next_s = stable_r;
    end
  end

  // Sync chain, debounce state and edge event registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_r   <= '0;
      prev_r   <= 1'b0;
      stable_r <= '0;
      level_r  <= 1'b0;
      armed_r  <= 1'b0;
      event_r  <= 1'b0;
      rise_r   <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], input_raw};
      prev_r   <= sync_s;
      stable_r <= stable_next_s;
      if (stable_next_s == DEB_MAX) begin
        level_r <= sync_s;
        armed_r <= 1'b1;
        event_r <= armed_r && (sync_s != level_r);
        rise_r  <= sync_s;
      end else begin
        event_r <= 1'b0;
      end
    end
  end

  assign input_level = level_r;
  assign edge_event  = event_r;
  assign edge_rise   = rise_r;

endmodule

// File: rtl/input_trigger_gen.sv
// Debounced edge trigger: fixed-width pulse, holdoff window, and saturating
// accepted/missed trigger counters.
module input_trigger_gen
  import input_trigger_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES  = 100,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic           Clk,
  input  logic           Reset,
  input_trigger_gen_if.slave bus
);
  localparam int               TW         = cnt_width((PULSE_CYCLES > HOLDOFF_CYCLES) ?
                                                      PULSE_CYCLES : HOLDOFF_CYCLES);
  localparam logic [TW-1:0]    T_ONE      = TW'(1);
  localparam logic [TW-1:0]    PULSE_LAST = TW'(PULSE_CYCLES);
  localparam logic [TW-1:0]    HOLD_LAST  = TW'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic             level_s;
  logic             edge_event_s;
  logic             edge_rise_s;
  logic             qualify_s;
  logic             accept_s;
  logic             missed_s;
  logic [1:0]       state_r;
  logic [TW-1:0]    timer_r;
  logic             trig_r;
  logic             busy_r;
  logic [CNT_W-1:0] trig_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  input_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .Clk         (Clk),
    .Reset       (Reset),
    .input_raw   (bus.Input_In),
    .input_level (level_s),
    .edge_event  (edge_event_s),
    .edge_rise   (edge_rise_s)
  );

  // Edge qualification against the selected edge type.
  always_comb begin
    qualify_s = 1'b0;
    case (bus.Edge_Sel)
      EDGE_RISE: qualify_s = edge_event_s && edge_rise_s;
      EDGE_FALL: qualify_s = edge_event_s && !edge_rise_s;
      EDGE_BOTH: qualify_s = edge_event_s;
      EDGE_NONE: qualify_s = 1'b0;
      default:   qualify_s = 1'b0;
    endcase
  end

  assign accept_s = qualify_s && bus.Enable && (state_r == ST_IDLE);
  assign missed_s = qualify_s && (state_r != ST_IDLE);

  // Pulse/holdoff sequencer; Enable only matters when leaving IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      trig_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_PULSE;
            timer_r <= T_ONE;
            trig_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (timer_r == PULSE_LAST) begin
            trig_r  <= 1'b0;
            timer_r <= T_ONE;
            if (HOLDOFF_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_HOLDOFF;
            end
          end else begin
            timer_r <= timer_r + T_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (timer_r == HOLD_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r + T_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= '0;
          trig_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating status counters; a clear beats a coincident increment.
  always_ff @(posedge Clk) begin
    if (Reset || bus.Count_Clr) begin
      trig_cnt_r <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (accept_s && (trig_cnt_r != CNT_MAX)) trig_cnt_r <= trig_cnt_r + C_ONE;
      if (missed_s && (miss_cnt_r != CNT_MAX)) miss_cnt_r <= miss_cnt_r + C_ONE;
    end
  end

  assign bus.Input_Level   = level_s;
  assign bus.Trigger_Out   = trig_r;
  assign bus.Trigger_Busy  = busy_r;
  assign bus.Trigger_Count = trig_cnt_r;
  assign bus.Missed_Count  = miss_cnt_r;

endmodule
